// File: rtl/capture_sequencer_pkg.sv
// Shared FSM state encoding and capture-mode constants for the capture sequencer.
// Constants only: no timing and no flow control.
package capture_sequencer_pkg;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_SEED       = 3'd1;
    localparam logic [2:0] ST_SETTLE     = 3'd2;
    localparam logic [2:0] ST_CAPTURE    = 3'd3;
    localparam logic [2:0] ST_RD_ISSUE   = 3'd4;
    localparam logic [2:0] ST_RD_WAIT    = 3'd5;
    localparam logic [2:0] ST_RD_PRESENT = 3'd6;
    localparam logic [2:0] ST_DONE       = 3'd7;

    localparam logic MODE_SINGLE = 1'b0;
    localparam logic MODE_RING   = 1'b1;

endpackage

// File: rtl/capture_ram.sv
// Single-port capture buffer RAM. Registered read with one-cycle latency.
// No backpressure: it accepts a write or a read on every cycle.
module capture_ram #(
    parameter int WIDTH      = 33,
    parameter int ADDR_WIDTH = 12,
    parameter int DEPTH      = 4096
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      q
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Read-first with no reset, so the array stays mappable onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        q <= mem[addr];
    end

endmodule

// File: rtl/capture_sequencer.sv
// Test-run sequencer: reseed, settle, burst-packed capture (single or ring), then readout oldest-first.
// Readout latency is 2 cycles per word. rd_valid/rd_data/rd_last hold until rd_ready.
module capture_sequencer
    import capture_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH    = 33,
    parameter int BURST         = 1,
    parameter int ADDR_WIDTH    = 12,
    parameter int DEPTH         = 4096,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        mode,
    input  logic                        stop,
    input  logic [DATA_WIDTH-1:0]       cap_data,
    output logic                        stim_reset,
    output logic                        stim_en,
    output logic                        busy,
    output logic                        done,
    output logic                        wrapped,
    output logic                        rd_valid,
    output logic [DATA_WIDTH*BURST-1:0] rd_data,
    output logic                        rd_last,
    input  logic                        rd_ready
);

    localparam int WORD_W = DATA_WIDTH * BURST;
    localparam int PACK_W = (BURST > 1) ? $clog2(BURST) : 1;
    localparam int SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int CNT_W  = ADDR_WIDTH + 1;

    localparam logic [PACK_W-1:0]     PACK_LAST   = PACK_W'(BURST - 1);
    localparam logic [SET_W-1:0]      SETTLE_LAST = SET_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [ADDR_WIDTH-1:0] PTR_LAST    = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [CNT_W-1:0]      CNT_FULL    = CNT_W'(DEPTH);

    logic [2:0]            state, state_nxt;
    logic                  mode_q;
    logic                  wrapped_q;
    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      count, remaining;
    logic [PACK_W-1:0]     pack_idx;
    logic [SET_W-1:0]      settle_cnt;
    logic [WORD_W-1:0]     pack_buf, full_word, ram_q, rd_data_q;

    logic                  start_acc, cap_stop, cap_take, word_wr, ptr_wrap, fill_done, rd_hs;
    logic [CNT_W-1:0]      n_words;

    assign start_acc = start && (state == ST_IDLE || state == ST_DONE);
    assign cap_stop  = (state == ST_CAPTURE) && stop;
    assign cap_take  = (state == ST_CAPTURE) && !stop;
    assign word_wr   = cap_take && (pack_idx == PACK_LAST);
    assign ptr_wrap  = (wr_ptr == PTR_LAST);
    assign fill_done = word_wr && (mode_q == MODE_SINGLE) && (count == CNT_FULL - 1'b1);
    assign n_words   = wrapped_q ? CNT_FULL : count;
    assign rd_hs     = (state == ST_RD_PRESENT) && rd_ready;

    // Current sample dropped into its slot; the first sample of a word lands in the LSBs.
    always_comb begin
        full_word = pack_buf;
        for (int j = 0; j < BURST; j++) begin
            if (pack_idx == PACK_W'(j)) begin
                full_word[j*DATA_WIDTH +: DATA_WIDTH] = cap_data;
            end
        end
    end

    capture_ram #(
        .WIDTH     (WORD_W),
        .ADDR_WIDTH(ADDR_WIDTH),
        .DEPTH     (DEPTH)
    ) u_ram (
        .clk  (clk),
        .we   (word_wr),
        .addr ((state == ST_CAPTURE) ? wr_ptr : rd_ptr),
        .wdata(full_word),
        .q    (ram_q)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: if (start) state_nxt = ST_SEED;
            ST_SEED:          state_nxt = (SETTLE_CYCLES == 0) ? ST_CAPTURE : ST_SETTLE;
            ST_SETTLE:        if (settle_cnt == SETTLE_LAST) state_nxt = ST_CAPTURE;
            ST_CAPTURE: begin
                // stop outranks the write that would complete a single-shot fill
                if (stop) begin
                    state_nxt = (n_words == '0) ? ST_DONE : ST_RD_ISSUE;
                end else if (fill_done) begin
                    state_nxt = ST_RD_ISSUE;
                end
            end
            ST_RD_ISSUE:      state_nxt = ST_RD_WAIT;
            ST_RD_WAIT:       state_nxt = ST_RD_PRESENT;
            ST_RD_PRESENT:    if (rd_ready) state_nxt = (remaining == CNT_W'(1)) ? ST_DONE : ST_RD_ISSUE;
            default:          state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        stim_reset = (state == ST_SEED);
        stim_en    = (state == ST_SETTLE) || (state == ST_CAPTURE);
        busy       = (state != ST_IDLE) && (state != ST_DONE);
        done       = (state == ST_DONE);
        wrapped    = wrapped_q;
        rd_valid   = (state == ST_RD_PRESENT);
        rd_last    = (state == ST_RD_PRESENT) && (remaining == CNT_W'(1));
        rd_data    = rd_data_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q     <= MODE_SINGLE;
            wrapped_q  <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            remaining  <= '0;
            pack_idx   <= '0;
            pack_buf   <= '0;
            settle_cnt <= '0;
            rd_data_q  <= '0;
        end else begin
            if (start_acc) begin
                mode_q     <= mode;
                wrapped_q  <= 1'b0;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                count      <= '0;
                remaining  <= '0;
                pack_idx   <= '0;
                pack_buf   <= '0;
                settle_cnt <= '0;
            end
            if (state == ST_SETTLE) begin
                settle_cnt <= settle_cnt + 1'b1;
            end
            if (cap_take) begin
                if (word_wr) begin
                    pack_idx <= '0;
                    wr_ptr   <= ptr_wrap ? '0 : wr_ptr + 1'b1;
                    if (count != CNT_FULL) begin
                        count <= count + 1'b1;
                    end
                    if (ptr_wrap && mode_q == MODE_RING) begin
                        wrapped_q <= 1'b1;
                    end
                end else begin
                    pack_idx <= pack_idx + 1'b1;
                    pack_buf <= full_word;
                end
            end
            // Readout starts at the oldest surviving word.
            if (cap_stop) begin
                pack_idx  <= '0;
                rd_ptr    <= wrapped_q ? wr_ptr : '0;
                remaining <= n_words;
            end
            if (fill_done) begin
                rd_ptr    <= '0;
                remaining <= CNT_FULL;
            end
            if (state == ST_RD_WAIT) begin
                rd_data_q <= ram_q;
            end
            if (rd_hs) begin
                rd_ptr    <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
                remaining <= remaining - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_capture_sequencer.sv
// Bench for capture_sequencer: directed vector table plus randomized runs against a word-list model.
module tb_capture_sequencer;

    localparam int DW     = 8;
    localparam int BURST  = 2;
    localparam int AW     = 2;
    localparam int DEPTH  = 4;
    localparam int SETTLE = 3;

    logic clk = 1'b0;
    logic reset, start, mode, stop, rd_ready;
    logic [DW-1:0] cap_data;
    logic stim_reset, stim_en, busy, done, wrapped, rd_valid, rd_last;
    logic [DW*BURST-1:0] rd_data;

    int checks = 0;
    int errors = 0;
    int en_cnt;
    logic [7:0]  samp_tab [256];
    logic [15:0] exp_q [$];

    typedef struct {
        string            name;
        bit               m;
        int               stop_at;
        int               rdy;
        bit               poke;
        int               n;
        logic [3:0][15:0] w;
        bit               wr;
    } vec_t;
    vec_t vecs [9];

    capture_sequencer #(
        .DATA_WIDTH   (DW),
        .BURST        (BURST),
        .ADDR_WIDTH   (AW),
        .DEPTH        (DEPTH),
        .SETTLE_CYCLES(SETTLE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mode      (mode),
        .stop      (stop),
        .cap_data  (cap_data),
        .stim_reset(stim_reset),
        .stim_en   (stim_en),
        .busy      (busy),
        .done      (done),
        .wrapped   (wrapped),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_last   (rd_last),
        .rd_ready  (rd_ready)
    );

    always #5 clk = ~clk;

    // cap_data is the sample-table entry indexed by stim_en-high edges since the reseed.
    always @(posedge clk or posedge reset) begin
        if (reset)           en_cnt <= 0;
        else if (stim_reset) en_cnt <= 0;
        else if (stim_en)    en_cnt <= en_cnt + 1;
    end
    assign cap_data = samp_tab[en_cnt[7:0]];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_flags"}, {25'd0, stim_reset, stim_en, busy, done, wrapped, rd_valid, rd_last}, 32'd0);
        chk({nm, "_rd_data"}, {16'd0, rd_data}, 32'd0);
    endtask

    task automatic set_vec(input int i, input string nm, input bit m, input int sa, input int rdy,
                           input bit poke, input int n, input logic [63:0] w, input bit wr);
        vecs[i].name = nm; vecs[i].m = m; vecs[i].stop_at = sa; vecs[i].rdy = rdy;
        vecs[i].poke = poke; vecs[i].n = n; vecs[i].w = w; vecs[i].wr = wr;
    endtask

    // Model: sample j of the capture is samp_tab[SETTLE+j]; pairs form words; ring keeps the newest DEPTH.
    task automatic build_model(input bit m, input int stop_at, output bit wr);
        int ns, full, first;
        exp_q.delete();
        if (!m) ns = (stop_at < 0 || stop_at >= BURST * DEPTH) ? BURST * DEPTH : stop_at;
        else    ns = stop_at;
        full  = ns / BURST;
        first = (m && full > DEPTH) ? full - DEPTH : 0;
        for (int i = first; i < full; i++)
            exp_q.push_back({samp_tab[SETTLE + 2*i + 1], samp_tab[SETTLE + 2*i]});
        wr = m && (full >= DEPTH);
    endtask

    task automatic do_run(input string nm, input bit m, input int stop_at, input int rdy,
                          input bit poke, input bit exp_wr);
        int n_got = 0, se_cnt = 0, sr_cnt = 0, hold = 0, done_cyc = -1;
        int n_exp = exp_q.size();
        int exp_se = SETTLE + ((!m && (stop_at < 0 || stop_at >= BURST * DEPTH)) ? BURST * DEPTH : stop_at + 1);
        @(negedge clk); start = 1'b1; mode = m; stop = 1'b0; rd_ready = 1'b1;
        @(negedge clk); start = 1'b0;
        chk({nm, "_done_clr"}, {31'd0, done}, 32'd0);
        chk({nm, "_busy_seed"}, {31'd0, busy}, 32'd1);
        for (int cyc = 1; cyc <= 400; cyc++) begin
            stop  = (cyc == 5 + stop_at);
            start = poke && (cyc == 3 || cyc == 16);
            mode  = ~m;
            if (rdy == 1) rd_ready = 1'($urandom_range(0, 1));
            else          rd_ready = 1'b1;
            if (rdy == 2 && rd_valid && n_got == 1 && hold < 5) begin
                rd_ready = 1'b0;
                hold++;
                chk({nm, "_bp_hold"}, {16'd0, rd_data}, {16'd0, exp_q[1]});
            end
            if (stim_en) se_cnt++;
            if (stim_reset) sr_cnt++;
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (rd_valid && rd_ready) begin
                chk({nm, "_word"}, {16'd0, rd_data}, (n_got < n_exp) ? {16'd0, exp_q[n_got]} : 32'hDEAD_BEEF);
                chk({nm, "_last"}, {31'd0, rd_last}, {31'd0, n_got == n_exp - 1});
                n_got++;
            end
            @(negedge clk);
        end
        stop = 1'b0; start = 1'b0;
        chk({nm, "_finished"}, {31'd0, done}, 32'd1);
        chk({nm, "_nwords"}, n_got, n_exp);
        chk({nm, "_busy_end"}, {31'd0, busy}, 32'd0);
        chk({nm, "_wrapped"}, {31'd0, wrapped}, {31'd0, exp_wr});
        chk({nm, "_stim_en_cycles"}, se_cnt, exp_se);
        chk({nm, "_stim_reset_cycles"}, sr_cnt, 1);
        if (n_exp == 0)
            chk({nm, "_done_latency"}, {31'd0, (done_cyc > 0) && (done_cyc - 5 - stop_at <= 2)}, 32'd1);
        if (rdy == 2)
            chk({nm, "_bp_cycles"}, hold, 5);
    endtask

    task automatic load_vec(input int i);
        for (int k = 0; k < 256; k++) samp_tab[k] = 8'(k);
        exp_q.delete();
        for (int k = 0; k < vecs[i].n; k++) exp_q.push_back(vecs[i].w[k]);
    endtask

    initial begin
        bit wr;
        int sa;
        bit m;
        reset = 1'b0; start = 1'b0; mode = 1'b0; stop = 1'b0; rd_ready = 1'b1;
        for (int k = 0; k < 256; k++) samp_tab[k] = 8'(k);

        set_vec(0, "single",       0, -1, 0, 0, 4, 64'h0A09_0807_0605_0403, 0);
        set_vec(1, "start_pokes",  0, -1, 0, 1, 4, 64'h0A09_0807_0605_0403, 0);
        set_vec(2, "backpressure", 0, -1, 2, 0, 4, 64'h0A09_0807_0605_0403, 0);
        set_vec(3, "ring_stop13",  1, 13, 0, 0, 4, 64'h0E0D_0C0B_0A09_0807, 1);
        set_vec(4, "ring_stop0",   1,  0, 0, 0, 0, 64'h0, 0);
        set_vec(5, "single_stop5", 0,  5, 0, 0, 2, 64'h0000_0000_0605_0403, 0);
        set_vec(6, "single_stop7", 0,  7, 0, 0, 3, 64'h0000_0807_0605_0403, 0);
        set_vec(7, "ring_stop8",   1,  8, 1, 0, 4, 64'h0A09_0807_0605_0403, 1);
        set_vec(8, "late_stop",    0,  9, 1, 0, 4, 64'h0A09_0807_0605_0403, 0);

        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        chk_all_zero("reset_init");
        reset = 1'b0;
        @(negedge clk);
        chk({"idle_busy"}, {31'd0, busy}, 32'd0);

        for (int i = 0; i < 9; i++) begin
            load_vec(i);
            do_run(vecs[i].name, vecs[i].m, vecs[i].stop_at, vecs[i].rdy, vecs[i].poke, vecs[i].wr);
        end

        // Reset in the middle of capture abandons the run; a fresh run then behaves as from power-up.
        @(negedge clk); start = 1'b1; mode = 1'b0;
        @(negedge clk); start = 1'b0;
        repeat (7) @(negedge clk);
        #2 reset = 1'b1;
        #1 chk_all_zero("reset_mid");
        @(negedge clk); reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_mid_done_stays0", {31'd0, done}, 32'd0);
        load_vec(0);
        do_run("after_reset", 0, -1, 0, 0, 0);

        for (int r = 0; r < 15; r++) begin
            for (int k = 0; k < 256; k++) samp_tab[k] = 8'($urandom);
            m  = 1'($urandom_range(0, 1));
            sa = m ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 10)) - 1;
            build_model(m, sa, wr);
            do_run("random", m, sa, 1, 0, wr);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/capture_sequencer.md
Name: capture_sequencer

Overview:
Parametrised successor to the single-shot capture controller in the hardware test harness. Sequences one test run:
- reseeds the stimulus LFSRs and gates their clock enable;
- discards DUT pipeline-settle samples;
- packs BURST DUT output samples per RAM word into an internal buffer, in single-shot or ring (continuous, keep-last-DEPTH) mode;
- streams the buffer out over a valid/ready port, oldest word first.

Parameters:
- DATA_WIDTH, 33: width of one DUT sample, i.e. (no_of_digits+1)*radix_bits.
- BURST, 1: samples packed per RAM word, ≥1.
- ADDR_WIDTH, 12: RAM address width.
- DEPTH, 4096: RAM words used, 2 ≤ DEPTH ≤ 2**ADDR_WIDTH.
- SETTLE_CYCLES, 2: enabled cycles discarded after seeding, ≥0.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  one-cycle request to begin a run.
- mode  in  1  0 = single-shot, 1 = ring; sampled when start is accepted.
- stop  in  1  ends capture; honoured only in CAPTURE.
- cap_data  in  DATA_WIDTH  DUT output sample.
- stim_reset  out  1  one-cycle reseed pulse to the stimulus LFSRs.
- stim_en  out  1  stimulus clock enable.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  run finished.
- wrapped  out  1  ring write pointer wrapped at least once.
- rd_valid  out  1  readout word valid.
- rd_data  out  DATA_WIDTH*BURST  readout word.
- rd_last  out  1  final readout word; qualified by rd_valid.
- rd_ready  in  1  consumer accepts the word.

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE.
  - All outputs 0, including rd_data.
  - Write pointer, read pointer, word count, burst packer and settle counter cleared.
  - RAM contents undefined.
  - Reset mid-run abandons the run; done stays 0.
- FSM states: IDLE, SEED, SETTLE, CAPTURE, RD_ISSUE, RD_WAIT, RD_PRESENT, DONE.
- IDLE or DONE + start:
  - Enter SEED; clear done, wrapped and all counters; latch mode.
  - start is ignored in every other state.
- SEED: exactly 1 cycle with stim_reset=1, stim_en=0. Then go to SETTLE, or directly to CAPTURE if SETTLE_CYCLES=0.
- SETTLE: stim_en=1 for exactly SETTLE_CYCLES cycles; cap_data is ignored.
- CAPTURE sampling and packing:
  - stim_en=1; cap_data is sampled on every clk edge in this state.
  - Sample j of a word occupies bits [j*DATA_WIDTH +: DATA_WIDTH], so the first sample is in the LSBs.
  - When the BURST-th sample is packed, the word is written at wr_ptr on that same edge; wr_ptr advances and count saturates at DEPTH.
  - wr_ptr wraps from DEPTH-1 to 0.
- CAPTURE exit, single-shot: after the DEPTH-th word is written, go to RD_ISSUE.
- CAPTURE exit, ring:
  - On a wrap, set wrapped and keep capturing.
  - Leave only on stop.
- Stop:
  - stop sampled high at an edge takes priority: cap_data at that edge is not captured.
  - A partially packed word is discarded.
  - stim_en is 0 from the next cycle; go to RD_ISSUE.
  - stop also ends single-shot capture early.
  - stop in any other state has no effect.
- Readout setup:
  - Start address rd_ptr = wrapped ? wr_ptr : 0.
  - Words to read N = wrapped ? DEPTH : count.
  - If N = 0, go directly to DONE.
- Readout sequence:
  - RAM has one-cycle read latency.
  - RD_ISSUE drives rd_ptr.
  - RD_WAIT registers q into rd_data.
  - RD_PRESENT holds rd_valid=1; rd_data and rd_last stay stable until rd_ready=1.
  - On the handshake, rd_ptr increments modulo DEPTH.
  - rd_last=1 on the N-th word.
  - After the last word go to DONE, otherwise back to RD_ISSUE. Minimum gap between words is therefore 2 cycles.
  - rd_valid=0 outside RD_PRESENT; rd_data holds its last value.
- DONE: done=1 held until the next accepted start.
- Simultaneous events:
  - stop at the edge that writes the DEPTH-th single-shot word: stop wins. That sample is not captured; count = DEPTH-1.
  - start and stop together in IDLE: start is accepted, stop is ignored.

Decomposition:
- Shared package: FSM state encoding (3-bit localparams) and the mode constants MODE_SINGLE=0, MODE_RING=1.
- One sub-module: capture_ram. Single-port RAM, DEPTH x DATA_WIDTH*BURST, with registered read (one-cycle latency) and write-enable. It wraps the on-chip RAM inference so that vendor RAM can be substituted later.
- Packer, pointers and FSM stay in capture_sequencer.

Test Plan:
All scenarios use DATA_WIDTH=8, BURST=2, DEPTH=4, SETTLE_CYCLES=3. The bench drives cap_data = number of stim_en-high edges so far, starting at 0.
1. Single-shot, rd_ready=1: start, mode=0 → stim_reset for 1 cycle. Then stim_en high for 3+8 cycles. Readout is 0x0403, 0x0605, 0x0807, 0x0A09, with rd_last on 0x0A09. Then done=1, busy=0, wrapped=0.
2. Ring stop after 13 captured samples (values 3..15): wrapped=1; the partial word {15} is discarded. Readout is 0x0807, 0x0A09, 0x0C0B, 0x0E0D, with rd_last on the 4th word.
3. Backpressure in scenario 1: hold rd_ready=0 for 5 cycles on word 2 → rd_valid=1 and rd_data=0x0605 stable for all 5 cycles. Total words is still 4.
4. Ring stop on the first CAPTURE edge → zero words. rd_valid never asserts; done=1 within 2 cycles.
5. Reset asserted mid-CAPTURE → all outputs 0 immediately. Then start again gives the exact result of scenario 1.
6. start pulsed during SETTLE and during readout → ignored and the result is unchanged. start in DONE → done clears and a new run begins.
